// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage.
//   XLEN, REG_ADDR_W, REG_COUNT : datapath, register index and register file sizes
//   F3_LB..F3_LHU               : load width/sign encodings of funct3
//   wb_state_e                  : writeback FSM state encoding
package wb_stage_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_COUNT  = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_MEM = 2'd1,
        S_COMMIT   = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// Load data alignment and extension (purely combinational).
//   data    : aligned 32-bit word from the data bus
//   funct3  : load width/sign code
//   addr_lo : byte offset of the load address
//   value   : register-ready load value (0 for an illegal code)
//   illegal : funct3 is not a supported load width
// Halfword loads use addr_lo[1] only; misaligned halfwords are not supported.
module wb_stage_load_align
    import wb_stage_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [W-1:0] data,
    input  logic [2:0]   funct3,
    input  logic [1:0]   addr_lo,
    output logic [W-1:0] value,
    output logic         illegal
);

    logic [W-1:0] byte_shift;
    logic [W-1:0] half_shift;
    logic [7:0]   byte_v;
    logic [15:0]  half_v;

    assign byte_shift = data >> {addr_lo, 3'b000};
    assign half_shift = data >> {addr_lo[1], 4'b0000};
    assign byte_v     = byte_shift[7:0];
    assign half_v     = half_shift[15:0];

    always_comb begin
        value   = '0;
        illegal = 1'b0;
        case (funct3)
            F3_LB:   value = {{(W-8){byte_v[7]}}, byte_v};
            F3_LH:   value = {{(W-16){half_v[15]}}, half_v};
            F3_LW:   value = data;
            F3_LBU:  value = {{(W-8){1'b0}}, byte_v};
            F3_LHU:  value = {{(W-16){1'b0}}, half_v};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage feeding the register file write port.
//   clk, rst (sync, active-low)
//   ex_*          : retiring instruction from execute (valid/ready handshake)
//   mem_rsp_*     : load data response from the data bus
//   write_*       : register file write port (one write per instruction)
//   busy_load/rd  : outstanding load, used by decode for stalls
//   load_err      : one-cycle pulse alongside the commit of an illegal load
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | nothing pending, ready to accept
// WAIT_MEM | load accepted, waiting for mem_rsp_valid, not ready
// COMMIT   | write port presents the retiring result, ready to accept
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int XLEN_P     = XLEN,
    parameter int REG_ADDR_P = REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic                  ex_wb_en,
    input  logic [REG_ADDR_P-1:0] ex_rd,
    input  logic [XLEN_P-1:0]     ex_result,
    input  logic                  ex_is_load,
    input  logic [2:0]            ex_funct3,
    input  logic [1:0]            ex_addr_lo,
    input  logic                  mem_rsp_valid,
    input  logic [XLEN_P-1:0]     mem_rsp_data,
    output logic                  write_en,
    output logic [REG_ADDR_P-1:0] write_addr,
    output logic [XLEN_P-1:0]     write_data,
    output logic                  busy_load,
    output logic [REG_ADDR_P-1:0] busy_rd,
    output logic                  load_err
);

    wb_state_e state, state_nxt;

    logic [REG_ADDR_P-1:0] ld_rd, ld_rd_nxt;
    logic [2:0]            ld_funct3, ld_funct3_nxt;
    logic [1:0]            ld_addr_lo, ld_addr_lo_nxt;
    logic                  ld_wb_en, ld_wb_en_nxt;

    logic                  write_en_nxt;
    logic [REG_ADDR_P-1:0] write_addr_nxt;
    logic [XLEN_P-1:0]     write_data_nxt;
    logic                  busy_load_nxt;
    logic [REG_ADDR_P-1:0] busy_rd_nxt;
    logic                  load_err_nxt;

    logic                  accept;
    logic [XLEN_P-1:0]     align_value;
    logic                  align_illegal;

    assign ex_ready = rst && (state != S_WAIT_MEM);
    assign accept   = ex_valid && ex_ready;

    wb_stage_load_align #(.W(XLEN_P)) u_align (
        .data    (mem_rsp_data),
        .funct3  (ld_funct3),
        .addr_lo (ld_addr_lo),
        .value   (align_value),
        .illegal (align_illegal)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            ld_rd      <= '0;
            ld_funct3  <= '0;
            ld_addr_lo <= '0;
            ld_wb_en   <= 1'b0;
            write_en   <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
            busy_load  <= 1'b0;
            busy_rd    <= '0;
            load_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            ld_rd      <= ld_rd_nxt;
            ld_funct3  <= ld_funct3_nxt;
            ld_addr_lo <= ld_addr_lo_nxt;
            ld_wb_en   <= ld_wb_en_nxt;
            write_en   <= write_en_nxt;
            write_addr <= write_addr_nxt;
            write_data <= write_data_nxt;
            busy_load  <= busy_load_nxt;
            busy_rd    <= busy_rd_nxt;
            load_err   <= load_err_nxt;
        end
    end

    // Writes to x0 run the full sequence but never strobe write_en; the
    // write port keeps its previous address/data whenever nothing is written.
    always_comb begin
        state_nxt      = state;
        ld_rd_nxt      = ld_rd;
        ld_funct3_nxt  = ld_funct3;
        ld_addr_lo_nxt = ld_addr_lo;
        ld_wb_en_nxt   = ld_wb_en;
        write_en_nxt   = 1'b0;
        write_addr_nxt = write_addr;
        write_data_nxt = write_data;
        busy_load_nxt  = busy_load;
        busy_rd_nxt    = busy_rd;
        load_err_nxt   = 1'b0;

        case (state)
            S_IDLE, S_COMMIT: begin
                if (accept) begin
                    if (ex_is_load) begin
                        state_nxt      = S_WAIT_MEM;
                        ld_rd_nxt      = ex_rd;
                        ld_funct3_nxt  = ex_funct3;
                        ld_addr_lo_nxt = ex_addr_lo;
                        ld_wb_en_nxt   = ex_wb_en;
                        busy_load_nxt  = 1'b1;
                        busy_rd_nxt    = ex_rd;
                    end else begin
                        state_nxt    = S_COMMIT;
                        write_en_nxt = ex_wb_en && (ex_rd != '0);
                        if (write_en_nxt) begin
                            write_addr_nxt = ex_rd;
                            write_data_nxt = ex_result;
                        end
                    end
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT_MEM: begin
                if (mem_rsp_valid) begin
                    state_nxt     = S_COMMIT;
                    busy_load_nxt = 1'b0;
                    load_err_nxt  = align_illegal;
                    write_en_nxt  = ld_wb_en && (ld_rd != '0);
                    if (write_en_nxt) begin
                        write_addr_nxt = ld_rd;
                        write_data_nxt = align_value;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
